// File: rtl/i2c_master_byte.sv
// Single-master I2C initiator: START, addr+R/W, ACK, one data byte, ACK/NACK, STOP per request.
// Latency: done at start+1+S*4*CLK_DIV clocks (S=20 full, S=11 on address NACK); start ignored while busy.
// Backpressure: none, one transaction in flight; SCL/SDA-enable are registered decodes of next state.
module i2c_master_byte #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       RESET_N,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output logic       SCL,
    output logic       sda_oe,
    input  logic       sda_in
);
    localparam int QW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP, S_DONE
    } state_t;

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    state_t        r_state;
    logic [QW-1:0] r_qcnt;
    logic [1:0]    r_q;
    logic [2:0]    r_bit;
    logic [7:0]    r_tx;
    logic [7:0]    r_rx;
    logic [7:0]    r_wdata;
    logic          r_rw;
    logic          r_nack;

    state_t        w_nxt_state;
    logic [QW-1:0] w_nxt_qcnt;
    logic [1:0]    w_nxt_q;
    logic [2:0]    w_nxt_bit;
    logic [7:0]    w_nxt_tx;
    logic          w_qwrap;
    logic          w_sample;
    logic          w_slot_end;

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_qwrap    = (r_qcnt == QW'(CLK_DIV - 1));
    assign w_sample   = w_qwrap && (r_q == 2'd2);
    assign w_slot_end = w_qwrap && (r_q == 2'd3);

    // Line levels for a given slot position: {SCL, sda_oe}.
    function automatic logic [1:0] f_drive(state_t s, logic [1:0] q, logic b, logic rd);
        logic [1:0] v;
        v = 2'b10;
        case (s)
            S_START:    v = (q < 2'd2) ? 2'b10 : (q == 2'd2) ? 2'b11 : 2'b01;
            S_ADDR:     v = {q[1], ~b};
            S_DATA:     v = {q[1], ~b & ~rd};
            S_ADDR_ACK,
            S_DATA_ACK: v = {q[1], 1'b0};
            S_STOP:     v = (q == 2'd0) ? 2'b01 : (q == 2'd3) ? 2'b10 : 2'b11;
            default:    v = 2'b10;
        endcase
        return v;
    endfunction

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_qcnt  = r_qcnt;
        w_nxt_q     = r_q;
        w_nxt_bit   = r_bit;
        w_nxt_tx    = r_tx;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nxt_state = S_START;
                    w_nxt_tx    = {addr, rw};
                    w_nxt_qcnt  = '0;
                    w_nxt_q     = 2'd0;
                    w_nxt_bit   = 3'd0;
                end
            end
            S_DONE: w_nxt_state = S_IDLE;
            default: begin
                w_nxt_qcnt = w_qwrap ? '0 : r_qcnt + QW'(1);
                w_nxt_q    = w_qwrap ? r_q + 2'd1 : r_q;
                if (w_slot_end) begin
                    case (r_state)
                        S_START: begin
                            w_nxt_state = S_ADDR;
                            w_nxt_bit   = 3'd0;
                        end
                        S_ADDR, S_DATA: begin
                            w_nxt_tx  = {r_tx[6:0], 1'b0};
                            w_nxt_bit = r_bit + 3'd1;
                            if (r_bit == 3'd7)
                                w_nxt_state = (r_state == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
                        end
                        S_ADDR_ACK: begin
                            if (r_nack) begin
                                w_nxt_state = S_STOP;
                            end else begin
                                w_nxt_state = S_DATA;
                                w_nxt_tx    = r_wdata;
                                w_nxt_bit   = 3'd0;
                            end
                        end
                        S_DATA_ACK: w_nxt_state = S_STOP;
                        S_STOP:     w_nxt_state = S_DONE;
                        default:    w_nxt_state = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
            r_qcnt  <= '0;
            r_q     <= 2'd0;
            r_bit   <= 3'd0;
            r_tx    <= 8'h00;
            r_rx    <= 8'h00;
            r_wdata <= 8'h00;
            r_rw    <= 1'b0;
            r_nack  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            rdata   <= 8'h00;
            SCL     <= 1'b1;
            sda_oe  <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_qcnt        <= w_nxt_qcnt;
            r_q           <= w_nxt_q;
            r_bit         <= w_nxt_bit;
            r_tx          <= w_nxt_tx;
            {SCL, sda_oe} <= f_drive(w_nxt_state, w_nxt_q, w_nxt_tx[7], r_rw);
            done          <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rw    <= rw;
                        r_wdata <= wdata;
                        ack_err <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_ADDR_ACK: begin
                    if (w_sample) begin
                        r_nack <= sda_in;
                        if (sda_in) ack_err <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_sample && r_rw) r_rx <= {r_rx[6:0], sda_in};
                end
                S_DATA_ACK: begin
                    // On reads the master NACKs, so the line level carries no error.
                    if (w_sample && !r_rw && sda_in) ack_err <= 1'b1;
                end
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    if (r_rw) rdata <= r_rx;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: behavioural I2C slave on the pins, scoreboard of expected transactions.
module tb_i2c_master_byte;
    logic       clk = 1'b0;
    logic       RESET_N = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = 7'h00;
    logic [7:0] wdata = 8'h00;
    logic       busy, done, ack_err, SCL, sda_oe, sda_in;
    logic [7:0] rdata;

    logic       sl_pull = 1'b0;
    assign sda_in = ~(sda_oe | sl_pull);

    i2c_master_byte #(.CLK_DIV(4)) dut (
        .clk(clk), .RESET_N(RESET_N), .start(start), .rw(rw), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata),
        .SCL(SCL), .sda_oe(sda_oe), .sda_in(sda_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_issued = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Slave model: oversamples the pins on the falling clock edge.
    logic        cfg_ack_addr = 1'b1;
    logic        cfg_ack_data = 1'b1;
    logic [7:0]  cfg_rdata = 8'h00;
    int          sl_cnt = 0;
    int          sl_stops = 0;
    logic [19:0] sl_bits = '0;
    logic        sl_rd = 1'b0;
    logic        psc = 1'b1;
    logic        psd = 1'b1;

    always @(negedge clk) begin
        logic csc, csd;
        csc = SCL;
        csd = sda_in;
        if (psc && csc && psd && !csd) begin
            sl_cnt = 0; sl_stops = 0; sl_bits = '0; sl_pull = 1'b0; sl_rd = 1'b0;
        end else if (psc && csc && !psd && csd) begin
            sl_stops++;
        end else if (!psc && csc) begin
            sl_cnt++;
            sl_bits = {sl_bits[18:0], csd};
        end else if (psc && !csc) begin
            sl_pull = 1'b0;
            if (sl_cnt == 8) begin
                sl_pull = cfg_ack_addr;
            end else if (sl_cnt == 9) begin
                sl_rd = sl_bits[1] && cfg_ack_addr;
                if (sl_rd) sl_pull = ~cfg_rdata[7];
            end else if (sl_cnt >= 10 && sl_cnt <= 16 && sl_rd) begin
                sl_pull = ~cfg_rdata[16 - sl_cnt];
            end else if (sl_cnt == 17 && !sl_rd) begin
                sl_pull = cfg_ack_data;
            end
        end
        psc = csc;
        psd = csd;
    end

    typedef struct {
        int          t0;
        int          lat;
        logic        aerr;
        logic [7:0]  rd;
        logic [19:0] bits;
        int          nrise;
    } exp_t;
    exp_t sb[$];

    // Monitor: every done pulse is matched against the oldest expected transaction.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            n_done++;
            chk("done_has_request", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("latency",     32'(cyc - e.t0),   32'(e.lat));
                chk("ack_err",     32'(ack_err),      32'(e.aerr));
                chk("rdata",       32'(rdata),        32'(e.rd));
                chk("bus_bits",    32'(sl_bits),      32'(e.bits));
                chk("scl_rises",   32'(sl_cnt),       32'(e.nrise));
                chk("stop_seen",   32'(sl_stops),     32'd1);
                chk("busy_at_done", 32'(busy),        32'd0);
            end
        end
    end

    task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] w,
                         input logic aa, input logic ad, input logic [7:0] srd,
                         input int lat, input logic eaerr, input logic [7:0] erd,
                         input logic [19:0] ebits, input int enr, output int t0);
        exp_t e;
        cfg_ack_addr = aa;
        cfg_ack_data = ad;
        cfg_rdata    = srd;
        addr = a; rw = r; wdata = w; start = 1'b1;
        t0 = cyc + 1;
        e.t0 = t0; e.lat = lat; e.aerr = eaerr; e.rd = erd; e.bits = ebits; e.nrise = enr;
        sb.push_back(e);
        n_issued++;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk({nm, "_timeout"}, 32'(done), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic pulse(input logic [6:0] a, input logic r, input logic [7:0] w);
        addr = a; rw = r; wdata = w; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        chk("rst_scl",     32'(SCL),     32'd1);
        chk("rst_sda_oe",  32'(sda_oe),  32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_ack_err", 32'(ack_err), 32'd0);
        chk("rst_rdata",   32'(rdata),   32'h00);
        RESET_N = 1'b1;
        repeat (5) @(negedge clk);

        // 1: write 0x05 <- 0xCC, both ACKed
        issue(7'h05, 1'b0, 8'hCC, 1'b1, 1'b1, 8'h00, 321, 1'b0, 8'h00,
              {7'h05, 1'b0, 1'b0, 8'hCC, 1'b0, 1'b0}, 19, t0);
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_done("t1");

        // 2: read 0x05 -> 0xA5, master NACKs the byte
        issue(7'h05, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA5, 321, 1'b0, 8'hA5,
              {7'h05, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0}, 19, t0);
        wait_done("t2");

        // 3: address NACK, data phase skipped
        issue(7'h3A, 1'b0, 8'h77, 1'b0, 1'b1, 8'h00, 177, 1'b1, 8'hA5,
              {7'h3A, 1'b0, 1'b1, 1'b0}, 10, t0);
        wait_done("t3");

        // 4: write data NACKed
        issue(7'h50, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h00, 321, 1'b1, 8'hA5,
              {7'h50, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0}, 19, t0);
        wait_done("t4");

        // 5: start pulses while busy and during the DONE cycle are ignored
        issue(7'h7F, 1'b0, 8'h81, 1'b1, 1'b1, 8'h00, 321, 1'b0, 8'hA5,
              {7'h7F, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0}, 19, t0);
        wait_cyc(t0 + 50);
        pulse(7'h00, 1'b1, 8'hFF);
        wait_cyc(t0 + 200);
        pulse(7'h2A, 1'b1, 8'h00);
        wait_cyc(t0 + 320);
        pulse(7'h11, 1'b1, 8'h0F);
        wait_done("t5");
        repeat (400) @(negedge clk);
        chk("t5_idle_after", 32'(busy), 32'd0);
        chk("t5_done_count", 32'(n_done), 32'(n_issued));

        // 6: reset during address bit 3 releases the bus at once
        issue(7'h55, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 321, 1'b0, 8'h00, '0, 19, t0);
        wait_cyc(t0 + 70);
        chk("t6_mid_scl_low", 32'(SCL), 32'd0);
        RESET_N = 1'b0;
        #1;
        chk("t6_rst_scl",    32'(SCL),    32'd1);
        chk("t6_rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("t6_rst_busy",   32'(busy),   32'd0);
        void'(sb.pop_back());
        n_issued--;
        @(negedge clk);
        RESET_N = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_rdata_cleared", 32'(rdata), 32'h00);
        issue(7'h11, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00, 321, 1'b0, 8'h00,
              {7'h11, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0}, 19, t0);
        wait_done("t6w");
        issue(7'h22, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 321, 1'b0, 8'h3C,
              {7'h22, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0}, 19, t0);
        wait_done("t6r");

        repeat (20) @(negedge clk);
        chk("sb_drained",  32'(sb.size()), 32'd0);
        chk("total_dones", 32'(n_done),    32'(n_issued));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
